// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 3x4 keypad scanner: FSM states, key codes,
// and the column/row to key-code decode.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      INTR_HOLD    = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   localparam logic [3:0] KEY_STAR  = 4'hA;
   localparam logic [3:0] KEY_HASH  = 4'hB;
   localparam logic [2:0] COL_FIRST = 3'b001;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   // Row 0 is the top row (1,2,3); column 0 is the left column.
   function automatic logic [3:0] decode_key(input logic [2:0] col, input logic [3:0] row);
      logic [3:0] code;
      code = 4'h0;
      case ({row, col})
         7'b0001_001: code = 4'h1;
         7'b0001_010: code = 4'h2;
         7'b0001_100: code = 4'h3;
         7'b0010_001: code = 4'h4;
         7'b0010_010: code = 4'h5;
         7'b0010_100: code = 4'h6;
         7'b0100_001: code = 4'h7;
         7'b0100_010: code = 4'h8;
         7'b0100_100: code = 4'h9;
         7'b1000_001: code = KEY_STAR;
         7'b1000_010: code = 4'h0;
         7'b1000_100: code = KEY_HASH;
         default:     code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous input pins, reset to zero.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-strobing keypad scanner with press/release debounce, single-key decode
// and an acknowledged interrupt to the MCU.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES = 100000,
   parameter int DB_CYCLES   = 500000,
   parameter int INTR_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   input  logic       intr_ack,
   output logic [2:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       intr,
   output state_e     dbg_state
);

   localparam int CNT_MAX_SD = (SCAN_CYCLES > DB_CYCLES) ? SCAN_CYCLES : DB_CYCLES;
   localparam int CNT_MAX    = (CNT_MAX_SD > INTR_CYCLES) ? CNT_MAX_SD : INTR_CYCLES;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] INTR_LAST = CNT_W'(INTR_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       col_q, col_d;
   logic [3:0]       row_cap_q, row_cap_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             intr_q, intr_d;
   logic [3:0]       row_s;
   logic [2:0]       col_next;

   sync_2ff #(.W(4)) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row),
      .q     (row_s)
   );

   assign col_next = {col_q[1:0], col_q[2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         cnt_q       <= '0;
         col_q       <= COL_FIRST;
         row_cap_q   <= 4'b0000;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         intr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         row_cap_q   <= row_cap_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         intr_q      <= intr_d;
      end
   end

   // One shared counter: dwell in SCAN, stable samples in DEBOUNCE and
   // WAIT_RELEASE, elapsed cycles in INTR_HOLD. Every state exit clears it.
   // intr/intr_ack handshake: intr rises one cycle after a key is accepted and
   // stays high until intr_ack is sampled high or INTR_CYCLES cycles elapse;
   // intr_ack in any other state has no effect.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      col_d       = col_q;
      row_cap_d   = row_cap_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      intr_d      = intr_q;

      case (state_q)
         SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (row_s != 4'b0000) begin
                  row_cap_d = row_s;
                  state_d   = DEBOUNCE;
               end else begin
                  col_d = col_next;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DEBOUNCE: begin
            if (row_s != row_cap_q) begin
               cnt_d   = '0;
               col_d   = col_next;
               state_d = SCAN;
            end else if (cnt_q == DB_LAST) begin
               cnt_d = '0;
               if (is_onehot4(row_cap_q)) begin
                  key_code_d  = decode_key(col_q, row_cap_q);
                  key_valid_d = 1'b1;
                  intr_d      = 1'b1;
                  state_d     = INTR_HOLD;
               end else begin
                  state_d = WAIT_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         INTR_HOLD: begin
            if (intr_ack || (cnt_q == INTR_LAST)) begin
               cnt_d   = '0;
               intr_d  = 1'b0;
               state_d = WAIT_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         WAIT_RELEASE: begin
            if (row_s != 4'b0000) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               cnt_d   = '0;
               col_d   = col_next;
               state_d = SCAN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = SCAN;
         end
      endcase
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign intr      = intr_q;
   assign dbg_state = state_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencing controller for the 3-column x 4-row phone keypad on the Basys3 PMOD. It strobes one column at a time and synchronises and debounces the row returns. It decodes a single pressed key to a 4-bit code and raises an interrupt for the MCU, holding it until acknowledged or timed out. It sits between the keypad pins and the MCU interrupt/input port; the seven-segment display logic consumes KEY_CODE.

Parameters:
SCAN_CYCLES, 100000, clock cycles each column is driven before the rows are sampled (1 ms at 100 MHz).
DB_CYCLES, 500000, consecutive stable cycles required for both press and release debounce.
INTR_CYCLES, 64, maximum cycles INTR stays high without INTR_ACK.

Ports:
CLK  input  1  system clock, 100 MHz
RST_N  input  1  asynchronous active-low reset
ROW  input  4  keypad row returns, active-high, bit0 = top row
INTR_ACK  input  1  MCU interrupt acknowledge, sampled each cycle
COL  output  3  one-hot active-high column drive, bit0 = left column
KEY_CODE  output  4  code of the last accepted key
KEY_VALID  output  1  sticky; set once the first key is accepted
INTR  output  1  interrupt request to the MCU

Behaviour:
- Clock and reset: one clock CLK; RST_N is asynchronous, active-low. Asserting RST_N at any time, including mid-debounce or mid-interrupt, immediately forces the reset values. The FSM restarts in SCAN on the first CLK edge after RST_N deasserts.
- Reset values: COL=3'b001, KEY_CODE=4'h0, KEY_VALID=0, INTR=0, state=SCAN, all counters and synchroniser flops 0.
- Input synchronisation: ROW passes through a 2-flop synchroniser (ROW_S), adding 2 cycles of latency. INTR_ACK is used directly because it is MCU-synchronous.
- Decode map (row r, col c): c0 = 1,4,7,*; c1 = 2,5,8,0; c2 = 3,6,9,#. Digits map to their value, * = 4'hA, # = 4'hB.
- SCAN state:
  - Dwell counter runs 0..SCAN_CYCLES-1 with COL constant.
  - On the terminal count: if ROW_S != 0, capture ROW_S into ROW_CAP and go to DEBOUNCE.
  - Otherwise rotate COL (001 -> 010 -> 100 -> 001) and reset the dwell counter.
- DEBOUNCE state:
  - COL is held. The counter increments while ROW_S == ROW_CAP.
  - Any mismatch: return to SCAN and advance COL.
  - Counter reaches DB_CYCLES with ROW_CAP one-hot: latch KEY_CODE, set KEY_VALID=1, assert INTR on the next cycle, go to INTR_HOLD.
  - Counter reaches DB_CYCLES with ROW_CAP not one-hot (multi-key): no INTR, KEY_CODE unchanged, go to WAIT_RELEASE.
- INTR_HOLD state:
  - INTR=1 until INTR_ACK==1 is sampled or INTR_CYCLES cycles have elapsed; then INTR=0 and go to WAIT_RELEASE.
  - ACK and timeout in the same cycle have the same effect as either alone.
  - INTR_ACK outside INTR_HOLD is ignored.
  - Key release during INTR_HOLD is ignored until exit.
- WAIT_RELEASE state:
  - COL is held. The counter increments while ROW_S == 0 and resets to 0 on any nonzero ROW_S.
  - Counter reaches DB_CYCLES: go to SCAN, advance COL, and clear the dwell counter.
- Latency: INTR rises exactly 1 cycle after the DB_CYCLES-th consecutive matching sample in DEBOUNCE.
- Output hold: KEY_CODE changes only on acceptance. A held key generates exactly one INTR; there is no auto-repeat.
- Widths: counters are sized $clog2(max(SCAN_CYCLES, DB_CYCLES, INTR_CYCLES)+1). Terminal compares are exact equality against parameter-1, with no wrap beyond the terminal value.

Decomposition:
- keypad_pkg:
  - state enum {SCAN, DEBOUNCE, INTR_HOLD, WAIT_RELEASE}
  - key code constants KEY_STAR=4'hA, KEY_HASH=4'hB
  - function decode_key(col one-hot, row one-hot) returning a 4-bit code
  - function is_onehot4
- Sub-module sync_2ff (parameterised width, CLK/RST_N) for ROW, so it can be reused for other asynchronous pins.

Test Plan (SCAN_CYCLES=4, DB_CYCLES=3, INTR_CYCLES=8):
1. Reset/idle: RST_N low then high, ROW=0 -> COL cycles 001,010,100 every 4 cycles; INTR=0, KEY_VALID=0, KEY_CODE=0.
2. Clean press '5': ROW=4'b0010 while COL=010, held stable -> KEY_CODE=4'h5, KEY_VALID=1, INTR high; INTR_ACK pulsed 2 cycles later -> INTR low next cycle. Release ROW=0 -> after 3 stable cycles COL advances to 100.
3. Timeout plus bounce: press '#' (COL=100, ROW=4'b1000) with no ACK -> INTR high exactly 8 cycles then low. A glitch ROW=0 for 1 cycle inside WAIT_RELEASE restarts the release count.
4. Bounce reject: ROW=4'b0001 on COL=001 for 2 cycles then 0 -> no INTR, KEY_CODE unchanged, COL advances to 010.
5. Multi-key: ROW=4'b0011 on COL=001 held -> no INTR, KEY_CODE unchanged, FSM waits for release, then scanning resumes.
6. Reset mid-INTR_HOLD: RST_N low while INTR=1 -> INTR, KEY_VALID, KEY_CODE cleared asynchronously, COL=001 before the next CLK edge.
